// File: rtl/laser_spot_tracker.sv
// Laser-spot locator: flags dominant-colour pixels, tracks horizontal hit runs
// and publishes the longest run of each frame one clock after its eof pixel.
module laser_spot_tracker #(
    parameter int unsigned COMP_W  = 8,
    parameter int unsigned COORD_W = 16,
    parameter int unsigned MIN_RUN = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 sof,
    input  logic                 eol,
    input  logic                 eof,
    input  logic [1:0]           chan_sel,
    input  logic [COMP_W-1:0]    threshold,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [3*COMP_W-1:0]  pixel,
    output logic [2*COORD_W-1:0] spot_xy,
    output logic [COORD_W-1:0]   spot_len,
    output logic                 spot_valid,
    output logic                 frame_done
);

    localparam logic [COORD_W-1:0] LEN_MAX = {COORD_W{1'b1}};

    typedef enum logic [1:0] {IDLE, GAP, RUN} state_t;

    state_t             state;
    logic [COORD_W-1:0] start_x, run_y, run_len;
    logic [COORD_W-1:0] best_len, best_x, best_y;

    logic [COMP_W-1:0]  comp_r, comp_g, comp_b;
    logic [COMP_W:0]    sel_c, other_sum, diff;
    logic               hit;

    assign comp_r = pixel[3*COMP_W-1:2*COMP_W];
    assign comp_b = pixel[2*COMP_W-1:COMP_W];
    assign comp_g = pixel[COMP_W-1:0];

    // Dominance test: selected channel minus the (unwrapped) sum of the other two
    always_comb begin
        case (chan_sel)
            2'd1: begin
                sel_c     = {1'b0, comp_g};
                other_sum = {1'b0, comp_r} + {1'b0, comp_b};
            end
            2'd2: begin
                sel_c     = {1'b0, comp_b};
                other_sum = {1'b0, comp_r} + {1'b0, comp_g};
            end
            default: begin
                sel_c     = {1'b0, comp_r};
                other_sum = {1'b0, comp_g} + {1'b0, comp_b};
            end
        endcase
        diff = (sel_c > other_sum) ? (sel_c - other_sum) : '0;
        hit  = diff > {1'b0, threshold};
    end

    logic               take_px, in_run, close_vld;
    logic [COORD_W-1:0] cur_len, cur_start, cur_y;
    logic [COORD_W-1:0] close_len, close_start, close_y;
    logic [COORD_W-1:0] nb_len, nb_x, nb_y;

    // Per-pixel run extension, run closing and best-run candidate selection
    always_comb begin
        take_px   = en && ((state != IDLE) || sof);
        in_run    = (state == RUN) && !sof;

        cur_len   = in_run ? ((run_len == LEN_MAX) ? run_len : run_len + COORD_W'(1))
                           : COORD_W'(1);
        cur_start = in_run ? start_x : x;
        cur_y     = in_run ? run_y : y;

        close_vld   = 1'b0;
        close_len   = run_len;
        close_start = start_x;
        close_y     = run_y;
        if (in_run && !hit) begin
            close_vld = 1'b1;
        end else if (hit && eol) begin
            close_vld   = 1'b1;
            close_len   = cur_len;
            close_start = cur_start;
            close_y     = cur_y;
        end

        // A sof pixel starts from an empty best so restarts discard old results
        nb_len = sof ? '0 : best_len;
        nb_x   = sof ? '0 : best_x;
        nb_y   = sof ? '0 : best_y;
        if (close_vld && (close_len > nb_len)) begin
            nb_len = close_len;
            nb_x   = close_start + ((close_len - COORD_W'(1)) >> 1);
            nb_y   = close_y;
        end
    end

    // State, run tracking and registered frame results
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_x    <= '0;
            run_y      <= '0;
            run_len    <= '0;
            best_len   <= '0;
            best_x     <= '0;
            best_y     <= '0;
            spot_xy    <= '0;
            spot_len   <= '0;
            spot_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (take_px) begin
                best_len <= nb_len;
                best_x   <= nb_x;
                best_y   <= nb_y;
                if (hit) begin
                    start_x <= cur_start;
                    run_y   <= cur_y;
                    run_len <= cur_len;
                end else begin
                    run_len <= '0;
                end
                if (eof) begin
                    state      <= IDLE;
                    spot_xy    <= {nb_x, nb_y};
                    spot_len   <= nb_len;
                    spot_valid <= nb_len >= COORD_W'(MIN_RUN);
                    frame_done <= 1'b1;
                end else if (hit && !eol) begin
                    state <= RUN;
                end else begin
                    state <= GAP;
                end
            end
        end
    end

endmodule

// File: tb/tb_laser_spot_tracker.sv
// Self-checking bench for laser_spot_tracker with a frame-level reference model.
module tb_laser_spot_tracker;

    logic        clk = 1'b0;
    logic        reset_n, en, sof, eol, eof;
    logic [1:0]  chan_sel;
    logic [7:0]  threshold;
    logic [15:0] x, y;
    logic [23:0] pixel;
    logic [31:0] spot_xy;
    logic [15:0] spot_len;
    logic        spot_valid, frame_done;

    laser_spot_tracker #(.COMP_W(8), .COORD_W(16), .MIN_RUN(5)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sof(sof), .eol(eol), .eof(eof),
        .chan_sel(chan_sel), .threshold(threshold), .x(x), .y(y), .pixel(pixel),
        .spot_xy(spot_xy), .spot_len(spot_len), .spot_valid(spot_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: remembers the accepted pixels of the current frame
    bit          m_active = 0;
    int          qx[$], qy[$];
    bit          qh[$], ql[$];
    logic [31:0] exp_xy = 0;
    logic [15:0] exp_len = 0;
    logic        exp_valid = 0;
    logic        exp_done = 0;

    logic [23:0] img [0:7][0:639];

    function automatic logic [23:0] px(input int r, input int g, input int b);
        return {8'(r), 8'(b), 8'(g)};
    endfunction

    function automatic bit ref_hit(input logic [1:0] cs, input int thr, input logic [23:0] p);
        int r, g, b, c, o, d;
        r = int'(p[23:16]); b = int'(p[15:8]); g = int'(p[7:0]);
        case (cs)
            2'd1:    begin c = g; o = r + b; end
            2'd2:    begin c = b; o = r + g; end
            default: begin c = r; o = g + b; end
        endcase
        d = (c > o) ? c - o : 0;
        return d > thr;
    endfunction

    // Longest horizontal run over the recorded frame; ties keep the earliest
    task automatic model_publish();
        int best = 0, bx = 0, by = 0, len = 0, sx = 0, ry = 0;
        for (int i = 0; i < qh.size(); i++) begin
            if (qh[i]) begin
                if (len == 0) begin sx = qx[i]; ry = qy[i]; end
                len++;
            end
            if (!qh[i] || ql[i]) begin
                if (len > best) begin best = len; bx = sx + (len - 1) / 2; by = ry; end
                len = 0;
            end
        end
        exp_len   = 16'(best);
        exp_xy    = {16'(bx), 16'(by)};
        exp_valid = best >= 5;
        exp_done  = 1'b1;
    endtask

    task automatic drive(input bit e, input bit s, input bit l, input bit f,
                         input int xx, input int yy, input logic [23:0] p);
        en = e; sof = s; eol = l; eof = f; x = 16'(xx); y = 16'(yy); pixel = p;
        exp_done = 1'b0;
        if (e) begin
            if (s) begin
                qx.delete(); qy.delete(); qh.delete(); ql.delete();
                m_active = 1;
            end
            if (m_active) begin
                qx.push_back(xx); qy.push_back(yy);
                qh.push_back(ref_hit(chan_sel, int'(threshold), p));
                ql.push_back(l);
                if (f) begin
                    model_publish();
                    m_active = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_garbage();
        drive(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 999),
              $urandom_range(0, 999), 24'($urandom));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b1; sof = 1'b0; eol = 1'b0; eof = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        en = 1'b0;
        m_active = 0; exp_xy = 0; exp_len = 0; exp_valid = 0; exp_done = 0;
    endtask

    task automatic clear_img();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 640; c++) img[r][c] = 24'h0;
    endtask

    // Raster-scan the image; optionally insert 3 en=0 cycles before one pixel
    task automatic send_img(input int w, input int h, input int gx, input int gy);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (r == gy && c == gx) repeat (3) idle_garbage();
                drive(1, r == 0 && c == 0, c == w - 1, r == h - 1 && c == w - 1, c, r, img[r][c]);
            end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spot_xy, spot_len, spot_valid, frame_done} !== 50'h0)
            $display("FAIL reset_outputs: got xy=%h len=%0d v=%b d=%b want all zero",
                     spot_xy, spot_len, spot_valid, frame_done);
        else passes++;
    endtask

    task automatic test_red_run();
        chan_sel = 2'd0; threshold = 8'd20;
        clear_img();
        for (int c = 10; c <= 17; c++) img[3][c] = px(200, 10, 10);
        send_img(20, 5, -1, -1);
        checks++;
        if (frame_done !== 1'b1) $display("FAIL red_done: got %b want 1", frame_done);
        else passes++;
        checks++;
        if (spot_xy !== {16'd13, 16'd3} || spot_len !== 16'd8 || spot_valid !== 1'b1)
            $display("FAIL red_result: got xy=%h len=%0d v=%b want xy=000d0003 len=8 v=1",
                     spot_xy, spot_len, spot_valid);
        else passes++;
        drive(0, 0, 0, 0, 0, 0, 24'h0);
        checks++;
        if (frame_done !== 1'b0 || spot_len !== 16'd8)
            $display("FAIL red_pulse_hold: got d=%b len=%0d want d=0 len=8", frame_done, spot_len);
        else passes++;
    endtask

    task automatic test_short_and_tie();
        chan_sel = 2'd0; threshold = 8'd20;
        clear_img();
        for (int c = 3; c <= 6; c++) img[1][c] = px(220, 5, 5);
        send_img(12, 3, -1, -1);
        checks++;
        if (frame_done !== 1'b1 || spot_len !== 16'd4 || spot_valid !== 1'b0 ||
            spot_xy !== {16'd4, 16'd1})
            $display("FAIL short_run: got d=%b len=%0d v=%b xy=%h want d=1 len=4 v=0 xy=00040001",
                     frame_done, spot_len, spot_valid, spot_xy);
        else passes++;
        clear_img();
        for (int c = 3; c <= 6; c++) img[1][c] = px(220, 5, 5);
        for (int c = 2; c <= 7; c++) img[2][c] = px(220, 5, 5);
        for (int c = 4; c <= 9; c++) img[5][c] = px(220, 5, 5);
        send_img(12, 7, -1, -1);
        checks++;
        if (spot_len !== 16'd6 || spot_valid !== 1'b1 || spot_xy !== {16'd4, 16'd2})
            $display("FAIL tie_first: got len=%0d v=%b xy=%h want len=6 v=1 xy=00040002",
                     spot_len, spot_valid, spot_xy);
        else passes++;
    endtask

    task automatic test_row_boundary();
        chan_sel = 2'd0; threshold = 8'd20;
        clear_img();
        for (int c = 636; c <= 639; c++) img[0][c] = px(200, 10, 10);
        for (int c = 0; c <= 3; c++) img[1][c] = px(200, 10, 10);
        send_img(640, 2, -1, -1);
        checks++;
        if (spot_len !== 16'd4 || spot_xy !== {16'd637, 16'd0} || spot_valid !== 1'b0)
            $display("FAIL row_boundary: got len=%0d xy=%h v=%b want len=4 xy=027d0000 v=0",
                     spot_len, spot_xy, spot_valid);
        else passes++;
    endtask

    task automatic test_threshold_edge();
        chan_sel = 2'd0; threshold = 8'd20;
        drive(1, 1, 1, 1, 7, 9, px(50, 15, 15));
        checks++;
        if (frame_done !== 1'b1 || spot_len !== 16'd0 || spot_xy !== 32'h0 || spot_valid !== 1'b0)
            $display("FAIL thr_equal: got d=%b len=%0d xy=%h want d=1 len=0 xy=0",
                     frame_done, spot_len, spot_xy);
        else passes++;
        drive(1, 1, 1, 1, 7, 9, px(51, 15, 15));
        checks++;
        if (spot_len !== 16'd1 || spot_xy !== {16'd7, 16'd9})
            $display("FAIL thr_plus1: got len=%0d xy=%h want len=1 xy=00070009", spot_len, spot_xy);
        else passes++;
        chan_sel = 2'd1; threshold = 8'd50;
        drive(1, 1, 1, 1, 2, 4, px(0, 100, 0));
        checks++;
        if (spot_len !== 16'd1 || spot_xy !== {16'd2, 16'd4})
            $display("FAIL green_hit: got len=%0d xy=%h want len=1 xy=00020004", spot_len, spot_xy);
        else passes++;
        chan_sel = 2'd0; threshold = 8'd0;
        drive(1, 1, 1, 1, 5, 5, px(255, 200, 200));
        checks++;
        if (spot_len !== 16'd0)
            $display("FAIL sum_no_wrap: got len=%0d want 0", spot_len);
        else passes++;
        chan_sel = 2'd3; threshold = 8'd0;
        drive(1, 1, 1, 1, 6, 1, px(9, 3, 2));
        checks++;
        if (spot_len !== 16'd1)
            $display("FAIL chan3_red: got len=%0d want 1", spot_len);
        else passes++;
    endtask

    task automatic test_en_gaps();
        chan_sel = 2'd2; threshold = 8'd10;
        clear_img();
        for (int c = 3; c <= 8; c++) img[0][c] = px(10, 10, 200);
        send_img(12, 2, 5, 0);
        checks++;
        if (spot_len !== 16'd6 || spot_xy !== {16'd5, 16'd0} || spot_valid !== 1'b1)
            $display("FAIL en_gap_run: got len=%0d xy=%h v=%b want len=6 xy=00050000 v=1",
                     spot_len, spot_xy, spot_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        chan_sel = 2'd0; threshold = 8'd20;
        clear_img();
        for (int c = 10; c <= 17; c++) img[3][c] = px(200, 10, 10);
        for (int c = 0; c < 6; c++) drive(1, c == 0, 0, 0, c, 0, px(200, 10, 10));
        do_reset();
        checks++;
        if ({spot_xy, spot_len, spot_valid, frame_done} !== 50'h0)
            $display("FAIL midreset_zero: got xy=%h len=%0d v=%b d=%b want zero",
                     spot_xy, spot_len, spot_valid, frame_done);
        else passes++;
        for (int c = 6; c < 12; c++) drive(1, 0, c == 11, c == 11, c, 0, px(200, 10, 10));
        checks++;
        if (frame_done !== 1'b0 || spot_len !== 16'd0)
            $display("FAIL no_sof_ignored: got d=%b len=%0d want d=0 len=0", frame_done, spot_len);
        else passes++;
        send_img(20, 5, -1, -1);
        checks++;
        if (frame_done !== 1'b1 || spot_xy !== {16'd13, 16'd3} || spot_len !== 16'd8)
            $display("FAIL fresh_frame: got d=%b xy=%h len=%0d want d=1 xy=000d0003 len=8",
                     frame_done, spot_xy, spot_len);
        else passes++;
    endtask

    // Random frames with gaps, restarts and changing channel/threshold, every cycle checked
    task automatic test_random();
        int w, h, errs;
        bit first;
        errs = 0;
        for (int f = 0; f < 40; f++) begin
            w = $urandom_range(1, 24);
            h = $urandom_range(1, 4);
            chan_sel  = 2'($urandom);
            threshold = 8'($urandom_range(0, 80));
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    logic [23:0] p;
                    if ($urandom_range(0, 5) == 0) idle_garbage();
                    if ($urandom_range(0, 20) == 0) begin
                        chan_sel  = 2'($urandom);
                        threshold = 8'($urandom_range(0, 80));
                    end
                    if ($urandom_range(0, 3) != 0)
                        p = {8'($urandom_range(150, 255)), 8'($urandom_range(0, 50)),
                             8'($urandom_range(0, 50))};
                    else
                        p = 24'($urandom);
                    first = (r == 0 && c == 0) || ($urandom_range(0, 60) == 0);
                    drive(1, first, c == w - 1, r == h - 1 && c == w - 1, c, r, p);
                    checks++;
                    if (frame_done !== exp_done || spot_xy !== exp_xy ||
                        spot_len !== exp_len || spot_valid !== exp_valid) begin
                        if (errs < 10)
                            $display("FAIL random f%0d: got d=%b xy=%h len=%0d v=%b want d=%b xy=%h len=%0d v=%b",
                                     f, frame_done, spot_xy, spot_len, spot_valid,
                                     exp_done, exp_xy, exp_len, exp_valid);
                        errs++;
                    end else passes++;
                end
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
        chan_sel = 2'd0; threshold = 8'd0; x = '0; y = '0; pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_red_run();
        test_short_and_tie();
        test_row_boundary();
        test_threshold_edge();
        test_en_gaps();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/laser_spot_tracker.md
Name: laser_spot_tracker

Overview:
- Per-frame laser-spot locator on the streaming pixel path.
- Per pixel: flags it as a "hit" when the selected colour channel exceeds the sum of the other two by more than a threshold.
- Tracks horizontal runs of hits. Keeps the longest run in the frame.
- At end of frame, publishes the run's centre coordinate, run length and a valid flag, and pulses frame_done. Downstream turret control consumes these outputs.

Parameters:
- COMP_W, 8, bits per colour component.
- COORD_W, 16, bits per coordinate and run-length counter.
- MIN_RUN, 5, minimum best-run length for spot_valid=1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- en  in  1  pixel valid; all other inputs are sampled only when en=1
- sof  in  1  first pixel of frame (qualified by en)
- eol  in  1  last pixel of row (qualified by en)
- eof  in  1  last pixel of frame (qualified by en); eof implies eol
- chan_sel  in  2  0=red, 1=green, 2=blue, 3=red
- threshold  in  COMP_W  dominance threshold
- x  in  COORD_W  pixel column
- y  in  COORD_W  pixel row
- pixel  in  3*COMP_W  R=[3W-1:2W], B=[2W-1:W], G=[W-1:0]
- spot_xy  out  2*COORD_W  {centre_x, row_y} of best run
- spot_len  out  COORD_W  best run length
- spot_valid  out  1  spot_len >= MIN_RUN
- frame_done  out  1  one-cycle pulse when outputs update

Behaviour:
- Hit detection (combinational):
  - C = selected component; O = sum of the other two, COMP_W+1 bits, no overflow.
  - d = (C > O) ? C - O : 0.
  - hit = d > threshold (strict).
- Reset (reset_n=0 at clk edge):
  - FSM -> IDLE; all counters cleared.
  - spot_xy=0, spot_len=0, spot_valid=0, frame_done=0.
  - Reset mid-frame discards the partial frame. The next frame is accepted only from a fresh sof.
- FSM states: IDLE, GAP (no open run), RUN (open run).
  - IDLE: ignores pixels until en&&sof.
    - The sof pixel is processed as the frame's first pixel: best cleared; hit -> RUN (start_x=x, len=1), else GAP.
  - GAP, en&&hit: RUN, start_x=x, run_y=y, len=1.
  - GAP, en&&!hit: stay in GAP.
  - RUN, en&&hit: len+1, saturating at 2^COORD_W-1.
  - RUN, en&&!hit: close run (length len, excluding this pixel) -> GAP.
  - RUN, eol with hit: close run including this pixel (len+1) -> GAP. Runs never span rows.
  - en=0: no state change, in any state.
- Close-run compare:
  - If closed length > best_len, update best_len, best_x=start_x+((length-1)>>1), best_y=run_y.
  - Ties keep the earlier run.
- Frame end:
  - On en&&eof, the pixel is processed first, including closing any open run with that pixel.
  - Next cycle:
    - spot_xy={best_x,best_y}, spot_len=best_len, spot_valid=(best_len>=MIN_RUN).
    - frame_done=1 for exactly one cycle.
    - FSM -> IDLE.
  - Latency from eof pixel to frame_done: 1 clk.
- Output hold: outputs hold the previous frame's result until the next frame_done; they are never cleared by sof.
- sof in GAP/RUN (frame restart, no eof): discard the open run and best; treat the pixel as a new first pixel; no frame_done.
- sof and eof on the same pixel: single-pixel frame; result published the next cycle.
- Zero-hit frame: spot_len=0, spot_xy=0, spot_valid=0, frame_done still pulses.
- chan_sel and threshold may change at any time; they take effect on the next pixel.

Test Plan:
- Red run: chan_sel=0, threshold=20. Row y=3: pixels x=10..17 = {R=200,G=10,B=10}, all others black; eof at end. -> 1 clk after eof: spot_xy={13,3}, spot_len=8, spot_valid=1, frame_done one-cycle pulse.
- Short run: 4-pixel hit run, MIN_RUN=5. -> spot_len=4, spot_valid=0. Equal runs of length 6 in rows 2 and 5 -> best_y=2 (tie keeps first).
- Row boundary: hits x=636..639 with eol at x=639, plus hits x=0..3 on the next row. -> two runs of 4; they are not merged into 8.
- Threshold edge: d == threshold -> no hit. d == threshold+1 -> hit. With chan_sel=1, pixel {R=0,G=100,B=0}, threshold=50 -> hit.
- en gaps: en deasserted for 3 cycles mid-run, with garbage pixel values presented during the gap. -> run length unaffected.
- Reset mid-frame, then a fresh sof frame. -> outputs 0 after reset; the new frame publishes correctly; no frame_done without eof.
